// File: rtl/signal_detect_mc.sv
// ============================================================================
// signal_detect_mc : per-channel run-length detector, PWM window / OWT bit mode
// Rev 1.0
// ============================================================================
`default_nettype none

module signal_detect_mc #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_mode,
  input  logic [CNT_W-1:0]        i_dn_th,
  input  logic [CNT_W-1:0]        i_up_th,
  input  logic [CH_NUM-1:0]       i_vld,
  input  logic [CH_NUM-1:0]       i_vld_data,
  output logic [CH_NUM-1:0]       o_vld,
  output logic [CH_NUM-1:0]       o_vld_data,
  output logic [CH_NUM*CNT_W-1:0] o_run_len,
  output logic [CH_NUM-1:0]       o_err
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic             last_vld_q, last_vld_d;
    logic             last_data_q, last_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             data_q, data_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             err_q, err_d;

    logic w_sample;
    logic w_pwm_win;
    logic w_owt_win;
    logic w_owt_short;

    assign w_sample    = i_vld_data[k];
    assign w_pwm_win   = (cnt_q >= i_dn_th) && (cnt_q <= i_up_th);
    assign w_owt_win   = (cnt_q >= i_dn_th) && (cnt_q <  i_up_th);
    assign w_owt_short = (cnt_q != '0) && (cnt_q < i_dn_th);

    always_comb begin
      last_vld_d  = last_vld_q;
      last_data_d = last_data_q;
      cnt_d       = cnt_q;
      vld_d       = 1'b0;
      err_d       = 1'b0;
      data_d      = data_q;
      len_d       = len_q;

      if (i_clr) begin
        last_vld_d  = 1'b0;
        last_data_d = 1'b0;
        cnt_d       = '0;
        data_d      = 1'b0;
        len_d       = '0;
      end else if (i_vld[k]) begin
        if (!last_vld_q) begin
          last_vld_d  = 1'b1;
          last_data_d = w_sample;
          cnt_d       = C_CNT_ONE;
        end else if (w_sample == last_data_q) begin
          // OWT emits a bit and restarts the count; otherwise the run keeps growing
          if (i_mode && w_owt_win) begin
            vld_d  = 1'b1;
            data_d = w_sample;
            len_d  = cnt_q + C_CNT_ONE;
            cnt_d  = '0;
          end else if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end else begin
          last_data_d = w_sample;
          cnt_d       = C_CNT_ONE;
          if (!i_mode) begin
            len_d = cnt_q;
            if (w_pwm_win) begin
              vld_d  = 1'b1;
              data_d = last_data_q;
            end else begin
              err_d = 1'b1;
            end
          end else if (w_owt_short) begin
            err_d = 1'b1;
            len_d = cnt_q;
          end
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        last_vld_q  <= 1'b0;
        last_data_q <= 1'b0;
        cnt_q       <= '0;
        vld_q       <= 1'b0;
        data_q      <= 1'b0;
        len_q       <= '0;
        err_q       <= 1'b0;
      end else begin
        last_vld_q  <= last_vld_d;
        last_data_q <= last_data_d;
        cnt_q       <= cnt_d;
        vld_q       <= vld_d;
        data_q      <= data_d;
        len_q       <= len_d;
        err_q       <= err_d;
      end
    end

    assign o_vld[k]                  = vld_q;
    assign o_vld_data[k]             = data_q;
    assign o_err[k]                  = err_q;
    assign o_run_len[k*CNT_W +: CNT_W] = len_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_signal_detect_mc.sv
// Bench for signal_detect_mc: directed table, hand sequences and a randomized
// run against a run-length reference model.
`default_nettype none

module tb_signal_detect_mc;

  localparam int CH = 4;
  localparam int W  = 10;
  localparam int MAXC = (1 << W) - 1;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          mode;
  logic [W-1:0]  dn, up;
  logic [CH-1:0] vld, dat;

  logic [CH-1:0]   o_vld, o_vld_data, o_err;
  logic [CH*W-1:0] o_run_len;

  logic       s_vld, s_dat, s_err;
  logic [3:0] s_len;

  signal_detect_mc #(.CH_NUM(CH), .CNT_W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_mode(mode),
    .i_dn_th(dn), .i_up_th(up), .i_vld(vld), .i_vld_data(dat),
    .o_vld(o_vld), .o_vld_data(o_vld_data), .o_run_len(o_run_len), .o_err(o_err)
  );

  signal_detect_mc #(.CH_NUM(1), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_mode(mode),
    .i_dn_th(dn[3:0]), .i_up_th(up[3:0]), .i_vld(vld[0]), .i_vld_data(dat[0]),
    .o_vld(s_vld), .o_vld_data(s_dat), .o_run_len(s_len), .o_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model: runs measured as plain integers
  int m_open [CH];
  int m_level[CH];
  int m_run  [CH];
  int e_vld  [CH];
  int e_err  [CH];
  int e_dat  [CH];
  int e_len  [CH];

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_open[k] = 0; m_level[k] = 0; m_run[k] = 0;
      e_vld[k] = 0; e_err[k] = 0; e_dat[k] = 0; e_len[k] = 0;
    end
  endtask

  task automatic model_clk();
    int d, run, lo, hi;
    lo = int'(dn);
    hi = int'(up);
    for (int k = 0; k < CH; k++) begin
      e_vld[k] = 0;
      e_err[k] = 0;
      d = int'(dat[k]);
      if (clr) begin
        m_open[k] = 0; m_run[k] = 0; e_dat[k] = 0; e_len[k] = 0;
      end else if (vld[k]) begin
        if (m_open[k] == 0) begin
          m_open[k] = 1; m_level[k] = d; m_run[k] = 1;
        end else if (d == m_level[k]) begin
          if (mode && m_run[k] >= lo && m_run[k] < hi) begin
            e_vld[k] = 1; e_dat[k] = d; e_len[k] = m_run[k] + 1; m_run[k] = 0;
          end else begin
            m_run[k] = (m_run[k] + 1 > MAXC) ? MAXC : m_run[k] + 1;
          end
        end else begin
          run = m_run[k];
          if (!mode) begin
            e_len[k] = run;
            if (run >= lo && run <= hi) begin
              e_vld[k] = 1; e_dat[k] = m_level[k];
            end else begin
              e_err[k] = 1;
            end
          end else if (run > 0 && run < lo) begin
            e_err[k] = 1; e_len[k] = run;
          end
          m_level[k] = d;
          m_run[k]   = 1;
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    logic [CH-1:0]   xv, xe, xd;
    logic [CH*W-1:0] xl;
    for (int k = 0; k < CH; k++) begin
      xv[k] = (e_vld[k] != 0);
      xe[k] = (e_err[k] != 0);
      xd[k] = (e_dat[k] != 0);
      xl[k*W +: W] = W'(e_len[k]);
    end
    check({nm, "_vld"},  64'(o_vld), 64'(xv));
    check({nm, "_err"},  64'(o_err), 64'(xe));
    check({nm, "_data"}, 64'(o_vld_data), 64'(xd));
    check({nm, "_len"},  64'(o_run_len), 64'(xl));
  endtask

  task automatic step(input logic c, input logic [CH-1:0] v, input logic [CH-1:0] d,
                      input string nm);
    clr = c; vld = v; dat = d;
    @(posedge clk);
    model_clk();
    #1;
    check_model(nm);
  endtask

  // ---------------- directed table (channel 0, PWM, dn=4 up=8)
  typedef struct {
    logic       clr;
    logic       v0;
    logic       d0;
    logic       e_vld;
    logic       e_err;
    logic       e_dat;
    logic [9:0] e_len;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int c, input int v, input int d,
                         input int ev, input int ee, input int ed, input int el);
    vec_t r;
    r.clr = (c != 0); r.v0 = (v != 0); r.d0 = (d != 0);
    r.e_vld = (ev != 0); r.e_err = (ee != 0); r.e_dat = (ed != 0);
    r.e_len = el[9:0];
    tbl.push_back(r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] cur;
    logic [CH-1:0] v;

    rst_n = 1'b0; clr = 1'b0; mode = 1'b0; dn = 10'd4; up = 10'd8;
    vld = '0; dat = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {o_vld, o_err, o_vld_data, o_run_len, s_vld, s_err, s_dat, s_len},
          '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table: valid window run, then short run, then long run
    add_vec(1,0,0, 0,0,0,0);
    for (int i = 0; i < 5; i++) add_vec(0,1,1, 0,0,0,0);
    add_vec(0,1,0, 1,0,1,5);
    add_vec(1,0,0, 0,0,0,0);
    for (int i = 0; i < 3; i++) add_vec(0,1,1, 0,0,0,0);
    add_vec(0,1,0, 0,1,0,3);
    for (int i = 0; i < 8; i++) add_vec(0,1,0, 0,0,0,3);
    add_vec(0,1,1, 0,1,0,9);
    foreach (tbl[i]) begin
      step(tbl[i].clr, {3'b000, tbl[i].v0}, {3'b000, tbl[i].d0}, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_ch0", i), 64'({o_vld[0], o_err[0], o_vld_data[0], o_run_len[9:0]}),
            64'({tbl[i].e_vld, tbl[i].e_err, tbl[i].e_dat, tbl[i].e_len}));
    end

    // ---- OWT on channel 1
    mode = 1'b1;
    step(1'b1, 4'b0000, 4'b0000, "owt_clr");
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 4'b0010, 4'b0010, "owt_run");
      if (i == 5 || i == 10)
        check($sformatf("owt_bit%0d", i), 64'({o_vld[1], o_err[1], o_vld_data[1], o_run_len[19:10]}),
              64'({1'b1, 1'b0, 1'b1, 10'd5}));
      else
        check($sformatf("owt_quiet%0d", i), 64'(o_vld[1]), 64'd0);
    end
    step(1'b0, 4'b0010, 4'b0010, "owt_tail");
    step(1'b0, 4'b0010, 4'b0010, "owt_tail");
    step(1'b0, 4'b0010, 4'b0000, "owt_short");
    check("owt_short_err", 64'({o_vld[1], o_err[1], o_run_len[19:10]}), 64'({1'b0, 1'b1, 10'd2}));

    // ---- saturation on the narrow instance
    mode = 1'b0;
    step(1'b1, 4'b0000, 4'b0000, "sat_clr");
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0001, 4'b0001, "sat_run");
    step(1'b0, 4'b0001, 4'b0000, "sat_end");
    check("sat_err", 64'({s_vld, s_err, s_len}), 64'({1'b0, 1'b1, 4'd15}));
    check("sat_wide_len", 64'({o_err[0], o_run_len[9:0]}), 64'({1'b1, 10'd20}));

    // ---- channel independence with a gapped strobe on ch3
    step(1'b1, 4'b0000, 4'b0000, "ind_clr");
    for (int i = 0; i < 12; i++) begin
      v = {(i % 2 == 0), (i >= 7), 1'b0, (i >= 7)};
      step(1'b0, v, 4'b1101, "ind_run");
    end
    step(1'b0, 4'b1101, 4'b0000, "ind_end");
    check("ind_vld", 64'({o_vld, o_err}), 64'({4'b1101, 4'b0000}));
    check("ind_len", 64'({o_run_len[39:30], o_run_len[29:20], o_run_len[9:0]}),
          64'({10'd6, 10'd5, 10'd5}));

    // ---- clear mid-run (clear wins over a simultaneous sample)
    step(1'b1, 4'b0000, 4'b0000, "clr_pre");
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 4'b0001, "clr_a");
    step(1'b1, 4'b0001, 4'b0001, "clr_hit");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0001, 4'b0001, "clr_b");
    step(1'b0, 4'b0001, 4'b0000, "clr_end");
    check("clr_result", 64'({o_vld[0], o_vld_data[0], o_run_len[9:0]}), 64'({1'b1, 1'b1, 10'd5}));

    // ---- asynchronous reset mid-run
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 4'b0001, "rst_a");
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_zero", {o_vld, o_err, o_vld_data, o_run_len, s_vld, s_err, s_dat, s_len}, '0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0001, 4'b0001, "rst_b");
    step(1'b0, 4'b0001, 4'b0000, "rst_end");
    check("rst_result", 64'({o_vld[0], o_vld_data[0], o_run_len[9:0]}), 64'({1'b1, 1'b1, 10'd5}));

    // ---- randomized traffic against the model
    cur = '0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        mode = 1'($urandom_range(0, 1));
        dn   = W'($urandom_range(0, 10));
        up   = W'($urandom_range(0, 12));
        step(1'b1, CH'($urandom), cur, "rnd_clr");
      end else begin
        if ($urandom_range(0, 99) < 2) begin
          dn = W'($urandom_range(0, 10));
          up = W'($urandom_range(0, 12));
        end
        for (int k = 0; k < CH; k++)
          if ($urandom_range(0, 99) < 15) cur[k] = ~cur[k];
        step(1'b0, CH'($urandom), cur, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
